// File: rtl/updown_ctrl_pkg.sv
// Shared definitions for the updown_ctrl slice.
//   deb_state_e : debounce FSM state encoding
//   clog2       : counter width helper (never returns less than 1)
package updown_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'b00,
        S_RISE_WAIT = 2'b01,
        S_HIGH      = 2'b10,
        S_FALL_WAIT = 2'b11
    } deb_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/updown_ctrl_if.sv
// Pushbutton / prescaler control bus of updown_ctrl.
//   btn_raw, en                      : driven by master (environment)
//   UpOrDown, tick, press, btn_db    : driven by slave (updown_ctrl)
interface updown_ctrl_if;

    logic btn_raw;
    logic en;
    logic UpOrDown;
    logic tick;
    logic press;
    logic btn_db;

    modport master (
        output btn_raw, en,
        input  UpOrDown, tick, press, btn_db
    );

    modport slave (
        input  btn_raw, en,
        output UpOrDown, tick, press, btn_db
    );

endinterface

// File: rtl/updown_ctrl_debounce.sv
// Two-FF synchronizer plus four-state debounce FSM for a raw pushbutton.
//   Clk, reset : clock, synchronous active-high reset
//   btn_raw_i  : asynchronous raw button level
//   btn_db_o   : debounced level (state decode)
//   press_o    : one-cycle pulse after an accepted press
//   accept_o   : strobe in the cycle whose closing edge accepts a press
module btn_debounce
    import updown_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic Clk,
    input  logic reset,
    input  logic btn_raw_i,
    output logic btn_db_o,
    output logic press_o,
    output logic accept_o
);

    localparam int unsigned   CW       = clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          s1_q;
    logic          btn_s_q;
    deb_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    always_ff @(posedge Clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            btn_s_q <= 1'b0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= btn_raw_i;
            btn_s_q <= s1_q;
            press_q <= 1'b0;
            case (state_q)
                S_LOW: begin
                    if (btn_s_q) begin
                        state_q <= S_RISE_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                S_RISE_WAIT: begin
                    if (!btn_s_q) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!btn_s_q) begin
                        state_q <= S_FALL_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                S_FALL_WAIT: begin
                    if (btn_s_q) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= S_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_db_o = (state_q == S_HIGH) || (state_q == S_FALL_WAIT);
    assign press_o  = press_q;
    // Decoded purely from registers so the direction FF can flip on the
    // same edge that loads press_q.
    assign accept_o = (state_q == S_RISE_WAIT) && btn_s_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/updown_ctrl.sv
// Direction / count-enable control stage feeding the up/down counter.
//   Clk, reset : clock, synchronous active-high reset
//   bus        : updown_ctrl_if.slave (btn_raw, en in; UpOrDown, tick,
//                press, btn_db out)
module updown_ctrl
    import updown_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TICK_DIV   = 10
) (
    input  logic         Clk,
    input  logic         reset,
    updown_ctrl_if.slave bus
);

    localparam int unsigned   DW       = clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic          press_w;
    logic          btn_db_w;
    logic          accept_w;

    logic          dir_q,  dir_d;
    logic [DW-1:0] div_q,  div_d;
    logic          tick_q, tick_d;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .Clk       (Clk),
        .reset     (reset),
        .btn_raw_i (bus.btn_raw),
        .btn_db_o  (btn_db_w),
        .press_o   (press_w),
        .accept_o  (accept_w)
    );

    always_comb begin
        dir_d  = dir_q ^ accept_w;
        div_d  = div_q;
        if (bus.en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        end
        // Registered tick: it is high exactly in the cycles where the
        // count sits at its last value after an enabled advance.
        tick_d = bus.en && (div_d == DIV_LAST);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            dir_q  <= 1'b0;
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            dir_q  <= dir_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign bus.UpOrDown = dir_q;
    assign bus.tick     = tick_q;
    assign bus.press    = press_w;
    assign bus.btn_db   = btn_db_w;

endmodule

// File: tb/tb_updown_ctrl.sv
// Self-checking bench for updown_ctrl with a behavioural reference model.
module tb_updown_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TDIV = 10;

    logic Clk;
    logic reset;

    updown_ctrl_if bus ();

    updown_ctrl #(
        .DEB_CYCLES (DEB),
        .TICK_DIV   (TDIV)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference model: raw input seen two edges late; accepted level flips
    // after DEB consecutive samples disagreeing with it; tick marks every
    // TDIV-th enabled step.
    bit          m_s1, m_s2, m_bs;
    bit          m_level, m_dir, m_press, m_tick;
    int unsigned m_streak, m_steps;

    always @(posedge Clk) begin
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_dir = 0;
            m_press = 0; m_tick = 0; m_streak = 0; m_steps = 0;
        end else begin
            m_bs = m_s2;
            m_s2 = m_s1;
            m_s1 = bus.btn_raw;
            m_press = 0;
            if (m_bs != m_level) begin
                m_streak++;
                if (m_streak == DEB) begin
                    m_level  = m_bs;
                    m_streak = 0;
                    if (m_bs) begin
                        m_press = 1;
                        m_dir   = !m_dir;
                    end
                end
            end else begin
                m_streak = 0;
            end
            if (bus.en) begin
                m_steps++;
                m_tick = (m_steps % TDIV) == TDIV - 1;
            end else begin
                m_tick = 0;
            end
        end
    end

    task automatic test_reset();
        reset = 1; bus.en = 1; bus.btn_raw = 0;
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if ({bus.UpOrDown, bus.press, bus.btn_db, bus.tick} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs got=%b exp=0000",
                         {bus.UpOrDown, bus.press, bus.btn_db, bus.tick});
            end
        end
        reset = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge Clk);
            checks++;
            if (bus.tick !== ((k % TDIV) == TDIV - 1)) begin
                errors++;
                $display("FAIL tick_period k=%0d got=%b exp=%b", k, bus.tick, (k % TDIV) == TDIV - 1);
            end
        end
    endtask

    task automatic test_press();
        bit dir0;
        dir0 = m_dir;
        bus.btn_raw = 1;
        for (int e = 0; e < 20; e++) begin
            @(negedge Clk);
            checks++;
            if ({bus.btn_db, bus.press, bus.UpOrDown} !==
                {e >= 5, e == 5, (e >= 5) ? !dir0 : dir0}) begin
                errors++;
                $display("FAIL press_latency e=%0d got=%b exp=%b", e,
                         {bus.btn_db, bus.press, bus.UpOrDown},
                         {e >= 5, e == 5, (e >= 5) ? !dir0 : dir0});
            end
        end
        bus.btn_raw = 0;
        for (int e = 0; e < 8; e++) begin
            @(negedge Clk);
            checks++;
            if ({bus.btn_db, bus.press, bus.UpOrDown} !== {e < 5, 1'b0, !dir0}) begin
                errors++;
                $display("FAIL release e=%0d got=%b exp=%b", e,
                         {bus.btn_db, bus.press, bus.UpOrDown}, {e < 5, 1'b0, !dir0});
            end
        end
    endtask

    task automatic test_glitch();
        bit dir0;
        dir0 = m_dir;
        for (int e = 0; e < 12; e++) begin
            bus.btn_raw = (e < 3);
            @(negedge Clk);
            checks++;
            if ({bus.btn_db, bus.press, bus.UpOrDown} !== {2'b00, dir0}) begin
                errors++;
                $display("FAIL glitch e=%0d got=%b exp=%b", e,
                         {bus.btn_db, bus.press, bus.UpOrDown}, {2'b00, dir0});
            end
        end
    endtask

    task automatic test_two_presses();
        reset = 1; bus.btn_raw = 0;
        @(negedge Clk);
        reset = 0;
        for (int p = 1; p <= 2; p++) begin
            bus.btn_raw = 1;
            repeat (8) @(negedge Clk);
            checks++;
            if (bus.UpOrDown !== (p == 1)) begin
                errors++;
                $display("FAIL two_press p=%0d got=%b exp=%b", p, bus.UpOrDown, p == 1);
            end
            bus.btn_raw = 0;
            for (int e = 0; e < 8; e++) begin
                @(negedge Clk);
                checks++;
                if ({bus.press, bus.UpOrDown} !== {1'b0, p == 1}) begin
                    errors++;
                    $display("FAIL two_press_release p=%0d got=%b exp=%b", p,
                             {bus.press, bus.UpOrDown}, {1'b0, p == 1});
                end
            end
        end
    endtask

    task automatic test_en_hold();
        reset = 1; bus.en = 1; bus.btn_raw = 0;
        @(negedge Clk);
        reset = 0;
        repeat (4) @(negedge Clk);
        bus.en = 0;
        repeat (7) begin
            @(negedge Clk);
            checks++;
            if (bus.tick !== 1'b0) begin
                errors++;
                $display("FAIL en_hold_tick got=%b exp=0", bus.tick);
            end
        end
        bus.en = 1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge Clk);
            checks++;
            if (bus.tick !== (j == 5)) begin
                errors++;
                $display("FAIL en_resume j=%0d got=%b exp=%b", j, bus.tick, j == 5);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1; bus.en = 1; bus.btn_raw = 0;
        @(negedge Clk);
        reset = 0;
        bus.btn_raw = 1;
        repeat (8) @(negedge Clk);
        bus.btn_raw = 0;
        repeat (8) @(negedge Clk);
        bus.btn_raw = 1;
        repeat (3) @(negedge Clk);
        checks++;
        if ({bus.UpOrDown, bus.btn_db} !== 2'b10) begin
            errors++;
            $display("FAIL mid_setup got=%b exp=10", {bus.UpOrDown, bus.btn_db});
        end
        reset = 1;
        @(negedge Clk);
        reset = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            checks++;
            if ({bus.UpOrDown, bus.btn_db, bus.press, bus.tick} !==
                {k >= 6, k >= 6, k == 6, (k % TDIV) == TDIV - 1}) begin
                errors++;
                $display("FAIL mid_reset k=%0d got=%b exp=%b", k,
                         {bus.UpOrDown, bus.btn_db, bus.press, bus.tick},
                         {k >= 6, k >= 6, k == 6, (k % TDIV) == TDIV - 1});
            end
        end
        bus.btn_raw = 0;
        repeat (8) @(negedge Clk);
    endtask

    task automatic test_random();
        int unsigned run;
        run = 0;
        reset = 0;
        for (int c = 0; c < 800; c++) begin
            if (run == 0) begin
                bus.btn_raw = $urandom_range(0, 1);
                run = $urandom_range(1, 9);
            end
            run--;
            if ($urandom_range(0, 15) == 0) bus.en = !bus.en;
            reset = ($urandom_range(0, 99) == 0);
            @(negedge Clk);
            checks++;
            if ({bus.UpOrDown, bus.press, bus.btn_db, bus.tick} !==
                {m_dir, m_press, m_level, m_tick}) begin
                errors++;
                $display("FAIL random c=%0d got=%b exp=%b", c,
                         {bus.UpOrDown, bus.press, bus.btn_db, bus.tick},
                         {m_dir, m_press, m_level, m_tick});
            end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1;
        bus.en = 1;
        bus.btn_raw = 0;
        test_reset();
        test_press();
        test_glitch();
        test_two_presses();
        test_en_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
